// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage LEGv8 pipeline with a shadow EX/MEM/WB scoreboard.
// Build option: define FORWARDING_EN to enable EX operand forwarding (load-use-only stalls).
module pipe_hazard_ctrl #(
    parameter int RA        = 5,
    parameter int ZREG      = 31,
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA-1:0]    id_rs1,
    input  logic [RA-1:0]    id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [RA-1:0]    id_rd,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [RA-1:0] ZR = RA'(ZREG);

    typedef struct packed {
        logic          rw;
        logic          mr;
        logic [RA-1:0] rd;
        logic [RA-1:0] rs1;
        logic [RA-1:0] rs2;
        logic          u1;
        logic          u2;
    } ex_ent_t;

    typedef struct packed {
        logic          rw;
        logic [RA-1:0] rd;
    } prod_ent_t;

    // Shadow scoreboard: _p0 = EX, _p1 = MEM, _p2 = WB
    logic      vld_p0, vld_p1, vld_p2;
    ex_ent_t   ex_p0;
    prod_ent_t mem_p1;
    prod_ent_t wb_p2;

    logic haz1, haz2, flush, stall;

    function automatic logic hit(input logic v, input logic rw,
                                 input logic [RA-1:0] rd, input logic [RA-1:0] r);
        return v & rw & (rd == r) & (r != ZR);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic en);
        return en ? c + CNT_W'(1) : c;
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [RA-1:0] r,
                                           input logic ex_v, input logic mem_v, input prod_ent_t m,
                                           input logic wb_v, input prod_ent_t w);
        if (!(ex_v && use_src))
            return 2'd0;
        if (hit(mem_v, m.rw, m.rd, r))
            return 2'd2;
        if (hit(wb_v, w.rw, w.rd, r))
            return 2'd1;
        return 2'd0;
    endfunction
`endif

    always_comb begin
        haz1         = 1'b0;
        haz2         = 1'b0;
        fwd_a        = 2'd0;
        fwd_b        = 2'd0;
`ifdef FORWARDING_EN
        haz1  = hit(vld_p0, ex_p0.rw, ex_p0.rd, id_rs1) & ex_p0.mr;
        haz2  = hit(vld_p0, ex_p0.rw, ex_p0.rd, id_rs2) & ex_p0.mr;
        fwd_a = fwd_sel(ex_p0.u1, ex_p0.rs1, vld_p0, vld_p1, mem_p1, vld_p2, wb_p2);
        fwd_b = fwd_sel(ex_p0.u2, ex_p0.rs2, vld_p0, vld_p1, mem_p1, vld_p2, wb_p2);
`else
        haz1 = hit(vld_p0, ex_p0.rw, ex_p0.rd, id_rs1)
             | hit(vld_p1, mem_p1.rw, mem_p1.rd, id_rs1)
             | (!RF_BYPASS & hit(vld_p2, wb_p2.rw, wb_p2.rd, id_rs1));
        haz2 = hit(vld_p0, ex_p0.rw, ex_p0.rd, id_rs2)
             | hit(vld_p1, mem_p1.rw, mem_p1.rd, id_rs2)
             | (!RF_BYPASS & hit(vld_p2, wb_p2.rw, wb_p2.rd, id_rs2));
`endif
        // A taken branch squashes the stalled instruction anyway, so it overrides the stall
        flush        = br_taken & !reset;
        stall        = id_valid & ((id_use1 & haz1) | (id_use2 & haz2)) & !flush & !reset;
        pc_en        = !stall;
        if_id_en     = !stall;
        if_id_flush  = flush;
        id_ex_bubble = stall | flush;
        ex_mem_flush = flush;
    end

`ifdef FORWARDING_EN
    logic unused_cfg;
    assign unused_cfg = RF_BYPASS;
`else
    logic unused_src;
    assign unused_src = ^{ex_p0.mr, ex_p0.rs1, ex_p0.rs2, ex_p0.u1, ex_p0.u2};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            vld_p0    <= id_valid & !stall & !flush;
            vld_p1    <= vld_p0 & !flush;
            vld_p2    <= vld_p1;
            stall_cnt <= cnt_step(stall_cnt, stall);
            flush_cnt <= cnt_step(flush_cnt, flush);
        end
    end

    always_ff @(posedge clk) begin
        ex_p0.rw  <= id_regwrite;
        ex_p0.mr  <= id_memread;
        ex_p0.rd  <= id_rd;
        ex_p0.rs1 <= id_rs1;
        ex_p0.rs2 <= id_rs2;
        ex_p0.u1  <= id_use1;
        ex_p0.u2  <= id_use2;
        mem_p1.rw <= ex_p0.rw;
        mem_p1.rd <= ex_p0.rd;
        wb_p2     <= mem_p1;
    end

endmodule
